swc_ib_ctrl: RTL and testbench

//  Per-port switch-core input block: a fabric sink receives frames and streams them into the multiport memory (MPM).

---
 rtl/swc_ib_ctrl_if.sv | 63 ++++++
 rtl/swc_ib_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_swc_ib_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/swc_ib_ctrl_if.sv
// swc_ib_ctrl_if: fabric sink, MMU, RTU, MPM and PTA signals of one switch input block
interface swc_ib_ctrl_if #(
    parameter int g_page_addr_width = 10,
    parameter int g_usecount_width  = 4,
    parameter int g_prio_width      = 3,
    parameter int g_ctrl_width      = 4,
    parameter int g_data_width      = 16,
    parameter int g_num_ports       = 11
);
    logic [g_data_width-1:0]      tx_data_i;
    logic [g_ctrl_width-1:0]      tx_ctrl_i;
    logic                         tx_bytesel_i;
    logic                         tx_valid_i;
    logic                         tx_sof_p1_i;
    logic                         tx_eof_p1_i;
    logic                         tx_rerror_p1_i;
    logic                         tx_dreq_o;
    logic                         mmu_page_alloc_req_o;
    logic                         mmu_page_alloc_done_i;
    logic [g_page_addr_width-1:0] mmu_pageaddr_i;
    logic [g_page_addr_width-1:0] mmu_pageaddr_o;
    logic                         mmu_force_free_o;
    logic                         mmu_set_usecnt_o;
    logic                         mmu_set_usecnt_done_i;
    logic [g_usecount_width-1:0]  mmu_usecnt_o;
    logic                         rtu_rsp_valid_i;
    logic                         rtu_rsp_ack_o;
    logic [g_num_ports-1:0]       rtu_dst_port_mask_i;
    logic                         rtu_drop_i;
    logic [g_prio_width-1:0]      rtu_prio_i;
    logic                         mpm_pckstart_o;
    logic [g_page_addr_width-1:0] mpm_pageaddr_o;
    logic                         mpm_pageend_i;
    logic [g_data_width-1:0]      mpm_data_o;
    logic [g_ctrl_width-1:0]      mpm_ctrl_o;
    logic                         mpm_drdy_o;
    logic                         mpm_full_i;
    logic                         mpm_flush_o;
    logic                         pta_transfer_pck_o;
    logic [g_page_addr_width-1:0] pta_pageaddr_o;
    logic [g_num_ports-1:0]       pta_mask_o;
    logic [g_prio_width-1:0]      pta_prio_o;

    modport slave (
        input  tx_data_i, tx_ctrl_i, tx_bytesel_i, tx_valid_i, tx_sof_p1_i, tx_eof_p1_i, tx_rerror_p1_i,
        input  mmu_page_alloc_done_i, mmu_pageaddr_i, mmu_set_usecnt_done_i,
        input  rtu_rsp_valid_i, rtu_dst_port_mask_i, rtu_drop_i, rtu_prio_i,
        input  mpm_pageend_i, mpm_full_i,
        output tx_dreq_o, mmu_page_alloc_req_o, mmu_pageaddr_o, mmu_force_free_o, mmu_set_usecnt_o, mmu_usecnt_o,
        output rtu_rsp_ack_o, mpm_pckstart_o, mpm_pageaddr_o, mpm_data_o, mpm_ctrl_o, mpm_drdy_o, mpm_flush_o,
        output pta_transfer_pck_o, pta_pageaddr_o, pta_mask_o, pta_prio_o
    );

    modport master (
        output tx_data_i, tx_ctrl_i, tx_bytesel_i, tx_valid_i, tx_sof_p1_i, tx_eof_p1_i, tx_rerror_p1_i,
        output mmu_page_alloc_done_i, mmu_pageaddr_i, mmu_set_usecnt_done_i,
        output rtu_rsp_valid_i, rtu_dst_port_mask_i, rtu_drop_i, rtu_prio_i,
        output mpm_pageend_i, mpm_full_i,
        input  tx_dreq_o, mmu_page_alloc_req_o, mmu_pageaddr_o, mmu_force_free_o, mmu_set_usecnt_o, mmu_usecnt_o,
        input  rtu_rsp_ack_o, mpm_pckstart_o, mpm_pageaddr_o, mpm_data_o, mpm_ctrl_o, mpm_drdy_o, mpm_flush_o,
        input  pta_transfer_pck_o, pta_pageaddr_o, pta_mask_o, pta_prio_o
    );
endinterface

// File: rtl/swc_ib_ctrl.sv
// swc_ib_ctrl: switch input block streaming fabric frames into the MPM and handing routed frames to the PTA
module swc_ib_ctrl #(
    parameter int g_page_addr_width = 10,
    parameter int g_usecount_width  = 4,
    parameter int g_prio_width      = 3,
    parameter int g_ctrl_width      = 4,
    parameter int g_data_width      = 16,
    parameter int g_num_ports       = 11
) (
    input logic          clk_i,
    input logic          rst_n_i,
    swc_ib_ctrl_if.slave ib
);
    typedef enum logic [2:0] {IDLE, RCV, WAIT_RTU, USECNT, XFER, DROP} state_t;
    localparam logic [31:0] c_uc_max = (32'd1 << g_usecount_width) - 32'd1;

    state_t                       state_q, state_d;
    logic                         page_rdy_q, page_rdy_d, alloc_req_q, alloc_req_d, pend_q, pend_d;
    logic [g_page_addr_width-1:0] next_page_q, next_page_d, pck_page_q, pck_page_d;
    logic [g_page_addr_width-1:0] mpm_page_q, mpm_page_d, mmu_page_q, mmu_page_d, pta_page_q, pta_page_d;
    logic                         rtu_got_q, rtu_got_d, rtu_drop_q, rtu_drop_d, rtu_ack_q, rtu_ack_d;
    logic [g_num_ports-1:0]       rtu_mask_q, rtu_mask_d, pta_mask_q, pta_mask_d;
    logic [g_prio_width-1:0]      rtu_prio_q, rtu_prio_d, pta_prio_q, pta_prio_d;
    logic                         dreq_q, dreq_d, pckstart_q, pckstart_d, drdy_q, drdy_d;
    logic                         free_q, free_d, set_uc_q, set_uc_d, flush_q, flush_d, xfer_q, xfer_d;
    logic [g_data_width-1:0]      data_q, data_d;
    logic [g_ctrl_width-1:0]      ctrl_q, ctrl_d;
    logic [g_usecount_width-1:0]  usecnt_q, usecnt_d;
    logic [31:0]                  pop;
    logic                         latch, to_drop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < g_num_ports; i++)
            pop = pop + 32'(rtu_mask_q[i]);
        state_d     = state_q;
        page_rdy_d  = page_rdy_q;
        pend_d      = pend_q;
        next_page_d = next_page_q;
        pck_page_d  = pck_page_q;
        mpm_page_d  = mpm_page_q;
        mmu_page_d  = mmu_page_q;
        pta_page_d  = pta_page_q;
        pta_mask_d  = pta_mask_q;
        pta_prio_d  = pta_prio_q;
        rtu_got_d   = rtu_got_q;
        rtu_drop_d  = rtu_drop_q;
        rtu_mask_d  = rtu_mask_q;
        rtu_prio_d  = rtu_prio_q;
        data_d      = data_q;
        ctrl_d      = ctrl_q;
        usecnt_d    = usecnt_q;
        set_uc_d    = set_uc_q;
        pckstart_d  = 1'b0;
        drdy_d      = 1'b0;
        free_d      = 1'b0;
        flush_d     = 1'b0;
        xfer_d      = 1'b0;
        to_drop     = 1'b0;
        // the RTU answer may arrive any time after the frame starts, but is taken once per frame
        latch       = ib.rtu_rsp_valid_i & ~rtu_got_q & (state_q inside {RCV, WAIT_RTU, DROP});
        rtu_ack_d   = latch;
        if (latch) begin
            rtu_got_d  = 1'b1;
            rtu_mask_d = ib.rtu_dst_port_mask_i;
            rtu_drop_d = ib.rtu_drop_i;
            rtu_prio_d = ib.rtu_prio_i;
        end
        if (alloc_req_q & ib.mmu_page_alloc_done_i) begin
            page_rdy_d  = 1'b1;
            next_page_d = ib.mmu_pageaddr_i;
        end
        if (state_q == RCV && ib.tx_valid_i) begin
            drdy_d = 1'b1;
            data_d = ib.tx_data_i;
            ctrl_d = ib.tx_bytesel_i ? '1 : ib.tx_ctrl_i;
        end
        case (state_q)
            IDLE: if (ib.tx_sof_p1_i && page_rdy_q) begin
                state_d    = RCV;
                pckstart_d = 1'b1;
                mpm_page_d = next_page_q;
                pck_page_d = next_page_q;
                page_rdy_d = 1'b0;
            end
            RCV: begin
                // a page boundary seen without a spare page is remembered until the prefetch lands
                if (ib.mpm_pageend_i || pend_q) begin
                    pend_d = ~page_rdy_q;
                    if (page_rdy_q) begin
                        mpm_page_d = next_page_q;
                        page_rdy_d = 1'b0;
                    end
                end
                if (ib.tx_rerror_p1_i) begin
                    to_drop = 1'b1;
                    pend_d  = 1'b0;
                end else if (ib.tx_eof_p1_i) begin
                    state_d = WAIT_RTU;
                    pend_d  = 1'b0;
                end
            end
            WAIT_RTU: if (rtu_got_q) begin
                if (rtu_drop_q || rtu_mask_q == '0)
                    to_drop = 1'b1;
                else begin
                    state_d    = USECNT;
                    set_uc_d   = 1'b1;
                    mmu_page_d = pck_page_q;
                    usecnt_d   = pop > c_uc_max ? '1 : pop[g_usecount_width-1:0];
                end
            end
            USECNT: if (ib.mmu_set_usecnt_done_i) begin
                state_d    = XFER;
                set_uc_d   = 1'b0;
                xfer_d     = 1'b1;
                pta_page_d = pck_page_q;
                pta_mask_d = rtu_mask_q;
                pta_prio_d = rtu_prio_q;
            end
            XFER: begin
                state_d   = IDLE;
                rtu_got_d = 1'b0;
            end
            DROP: if (rtu_got_q) begin
                state_d   = IDLE;
                rtu_got_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (to_drop) begin
            state_d    = DROP;
            flush_d    = 1'b1;
            free_d     = 1'b1;
            mmu_page_d = pck_page_q;
        end
        alloc_req_d = ~page_rdy_d;
        dreq_d      = page_rdy_d & ~ib.mpm_full_i & (state_d inside {IDLE, RCV});
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            page_rdy_q  <= 1'b0;
            alloc_req_q <= 1'b0;
            pend_q      <= 1'b0;
            next_page_q <= '0;
            pck_page_q  <= '0;
            mpm_page_q  <= '0;
            mmu_page_q  <= '0;
            pta_page_q  <= '0;
            pta_mask_q  <= '0;
            pta_prio_q  <= '0;
            rtu_got_q   <= 1'b0;
            rtu_drop_q  <= 1'b0;
            rtu_mask_q  <= '0;
            rtu_prio_q  <= '0;
            rtu_ack_q   <= 1'b0;
            dreq_q      <= 1'b0;
            pckstart_q  <= 1'b0;
            drdy_q      <= 1'b0;
            free_q      <= 1'b0;
            set_uc_q    <= 1'b0;
            flush_q     <= 1'b0;
            xfer_q      <= 1'b0;
            data_q      <= '0;
            ctrl_q      <= '0;
            usecnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            page_rdy_q  <= page_rdy_d;
            alloc_req_q <= alloc_req_d;
            pend_q      <= pend_d;
            next_page_q <= next_page_d;
            pck_page_q  <= pck_page_d;
            mpm_page_q  <= mpm_page_d;
            mmu_page_q  <= mmu_page_d;
            pta_page_q  <= pta_page_d;
            pta_mask_q  <= pta_mask_d;
            pta_prio_q  <= pta_prio_d;
            rtu_got_q   <= rtu_got_d;
            rtu_drop_q  <= rtu_drop_d;
            rtu_mask_q  <= rtu_mask_d;
            rtu_prio_q  <= rtu_prio_d;
            rtu_ack_q   <= rtu_ack_d;
            dreq_q      <= dreq_d;
            pckstart_q  <= pckstart_d;
            drdy_q      <= drdy_d;
            free_q      <= free_d;
            set_uc_q    <= set_uc_d;
            flush_q     <= flush_d;
            xfer_q      <= xfer_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            usecnt_q    <= usecnt_d;
        end
    end

    assign ib.tx_dreq_o            = dreq_q;
    assign ib.mmu_page_alloc_req_o = alloc_req_q;
    assign ib.mmu_pageaddr_o       = mmu_page_q;
    assign ib.mmu_force_free_o     = free_q;
    assign ib.mmu_set_usecnt_o     = set_uc_q;
    assign ib.mmu_usecnt_o         = usecnt_q;
    assign ib.rtu_rsp_ack_o        = rtu_ack_q;
    assign ib.mpm_pckstart_o       = pckstart_q;
    assign ib.mpm_pageaddr_o       = mpm_page_q;
    assign ib.mpm_data_o           = data_q;
    assign ib.mpm_ctrl_o           = ctrl_q;
    assign ib.mpm_drdy_o           = drdy_q;
    assign ib.mpm_flush_o          = flush_q;
    assign ib.pta_transfer_pck_o   = xfer_q;
    assign ib.pta_pageaddr_o       = pta_page_q;
    assign ib.pta_mask_o           = pta_mask_q;
    assign ib.pta_prio_o           = pta_prio_q;
endmodule

// File: tb/tb_swc_ib_ctrl.sv
// tb_swc_ib_ctrl: directed scenarios for the switch input block with an MMU responder in the clock task
module tb_swc_ib_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0, failures = 0;
    int   alloc_pg = 5, wcnt = 0;
    logic auto_alloc = 1'b0;
    int   n_drdy, n_pck, n_ack, n_flush, n_free, n_pta, n_uc;
    logic [9:0]  pck_pg, free_pg, pta_pg, uc_pg;
    logic [10:0] pta_msk;
    logic [2:0]  pta_pri;
    logic [3:0]  uc_val, first_ctrl, last_ctrl;
    logic [15:0] first_data, last_data;

    swc_ib_ctrl_if b();
    swc_ib_ctrl dut (.clk_i(clk), .rst_n_i(rst_n), .ib(b));

    always #5 clk = ~clk;

    task automatic clr();
        n_drdy = 0; n_pck = 0; n_ack = 0; n_flush = 0; n_free = 0; n_pta = 0; n_uc = 0;
        pck_pg = '0; free_pg = '0; pta_pg = '0; uc_pg = '0; pta_msk = '0; pta_pri = '0; uc_val = '0;
        first_ctrl = '0; last_ctrl = '0; first_data = '0; last_data = '0; wcnt = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (b.mpm_drdy_o) begin
            if (n_drdy == 0) begin first_data = b.mpm_data_o; first_ctrl = b.mpm_ctrl_o; end
            last_data = b.mpm_data_o; last_ctrl = b.mpm_ctrl_o; n_drdy++;
        end
        if (b.mpm_pckstart_o) begin n_pck++; pck_pg = b.mpm_pageaddr_o; end
        if (b.rtu_rsp_ack_o) n_ack++;
        if (b.mpm_flush_o) n_flush++;
        if (b.mmu_force_free_o) begin n_free++; free_pg = b.mmu_pageaddr_o; end
        if (b.pta_transfer_pck_o) begin n_pta++; pta_pg = b.pta_pageaddr_o; pta_msk = b.pta_mask_o; pta_pri = b.pta_prio_o; end
        if (b.mmu_set_usecnt_o) begin n_uc++; uc_val = b.mmu_usecnt_o; uc_pg = b.mmu_pageaddr_o; end
        b.mmu_page_alloc_done_i = auto_alloc & b.mmu_page_alloc_req_o & ~b.mmu_page_alloc_done_i;
        if (b.mmu_page_alloc_done_i) begin b.mmu_pageaddr_i = 10'(alloc_pg); alloc_pg++; end
        b.mmu_set_usecnt_done_i = b.mmu_set_usecnt_o & ~b.mmu_set_usecnt_done_i;
    endtask

    task automatic wait_dreq();
        int g = 0;
        while (!b.tx_dreq_o && g < 50) begin tick(); g++; end
        if (!b.tx_dreq_o) begin checks++; failures++; $display("FAIL dreq_timeout got=0 exp=1"); end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; auto_alloc = 1'b0; b.mpm_full_i = 0; b.mpm_pageend_i = 0; b.rtu_rsp_valid_i = 0;
        tick(); tick();
        rst_n = 1'b1; alloc_pg = 5; auto_alloc = 1'b1;
        wait_dreq();
        clr();
    endtask

    task automatic send_words(input int n, input logic last_byte);
        for (int i = 0; i < n; i++) begin
            b.tx_valid_i = 1'b0;
            wait_dreq();
            b.tx_valid_i = 1'b1; b.tx_data_i = 16'h1000 + 16'(wcnt); b.tx_ctrl_i = 4'h1;
            b.tx_bytesel_i = last_byte && i == n - 1; wcnt++;
            tick();
        end
        b.tx_valid_i = 1'b0; b.tx_bytesel_i = 1'b0;
    endtask

    task automatic sof();
        wait_dreq();
        b.tx_sof_p1_i = 1'b1; tick(); b.tx_sof_p1_i = 1'b0;
    endtask

    task automatic eof_drain();
        b.tx_eof_p1_i = 1'b1; tick(); b.tx_eof_p1_i = 1'b0;
        repeat (10) tick();
    endtask

    task automatic rtu(input logic v, input logic [10:0] m, input logic d, input logic [2:0] p);
        b.rtu_rsp_valid_i = v; b.rtu_dst_port_mask_i = m; b.rtu_drop_i = d; b.rtu_prio_i = p;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; auto_alloc = 1'b0;
        tick(); tick();
        checks++; if ({b.mmu_page_alloc_req_o, b.tx_dreq_o, b.mpm_pckstart_o, b.mpm_drdy_o, b.mpm_flush_o, b.mmu_force_free_o, b.pta_transfer_pck_o, b.rtu_rsp_ack_o, b.mmu_set_usecnt_o} !== 9'd0) begin failures++; $display("FAIL reset_strobes got=%b exp=0", {b.mmu_page_alloc_req_o, b.tx_dreq_o, b.mpm_pckstart_o, b.mpm_drdy_o, b.mpm_flush_o, b.mmu_force_free_o, b.pta_transfer_pck_o, b.rtu_rsp_ack_o, b.mmu_set_usecnt_o}); end
        checks++; if ({b.mpm_pageaddr_o, b.mmu_pageaddr_o, b.pta_pageaddr_o} !== 30'd0) begin failures++; $display("FAIL reset_pages got=%h exp=0", {b.mpm_pageaddr_o, b.mmu_pageaddr_o, b.pta_pageaddr_o}); end
        rst_n = 1'b1; alloc_pg = 5;
        tick();
        checks++; if (b.mmu_page_alloc_req_o !== 1'b1) begin failures++; $display("FAIL alloc_req_rise got=%b exp=1", b.mmu_page_alloc_req_o); end
        checks++; if (b.tx_dreq_o !== 1'b0) begin failures++; $display("FAIL dreq_no_page got=%b exp=0", b.tx_dreq_o); end
        auto_alloc = 1'b1;
        tick(); tick();
        checks++; if (b.mmu_page_alloc_req_o !== 1'b0) begin failures++; $display("FAIL alloc_req_fall got=%b exp=0", b.mmu_page_alloc_req_o); end
        checks++; if (b.tx_dreq_o !== 1'b1) begin failures++; $display("FAIL dreq_page_ready got=%b exp=1", b.tx_dreq_o); end
    endtask

    task automatic test_frame();
        do_reset();
        rtu(1'b1, 11'h006, 1'b0, 3'd2);
        sof();
        send_words(100, 1'b1);
        eof_drain();
        rtu(1'b0, 11'h0, 1'b0, 3'd0);
        checks++; if (n_drdy !== 100) begin failures++; $display("FAIL frame_drdy got=%0d exp=100", n_drdy); end
        checks++; if (n_pck !== 1 || pck_pg !== 10'd5) begin failures++; $display("FAIL frame_pckstart got=%0d/%0d exp=1/5", n_pck, pck_pg); end
        checks++; if (n_ack !== 1) begin failures++; $display("FAIL frame_ack_once got=%0d exp=1", n_ack); end
        checks++; if (uc_val !== 4'd2 || uc_pg !== 10'd5) begin failures++; $display("FAIL frame_usecnt got=%0d/%0d exp=2/5", uc_val, uc_pg); end
        checks++; if (n_pta !== 1 || pta_pg !== 10'd5) begin failures++; $display("FAIL frame_pta got=%0d/%0d exp=1/5", n_pta, pta_pg); end
        checks++; if (pta_msk !== 11'h006 || pta_pri !== 3'd2) begin failures++; $display("FAIL frame_pta_route got=%h/%0d exp=006/2", pta_msk, pta_pri); end
        checks++; if (n_flush !== 0 || n_free !== 0) begin failures++; $display("FAIL frame_no_drop got=%0d/%0d exp=0/0", n_flush, n_free); end
        checks++; if (first_data !== 16'h1000 || first_ctrl !== 4'h1) begin failures++; $display("FAIL frame_first_word got=%h/%h exp=1000/1", first_data, first_ctrl); end
        checks++; if (last_data !== 16'h1063 || last_ctrl !== 4'hF) begin failures++; $display("FAIL frame_byte_word got=%h/%h exp=1063/f", last_data, last_ctrl); end
    endtask

    task automatic test_drop();
        do_reset();
        rtu(1'b1, 11'h006, 1'b1, 3'd2);
        sof(); send_words(10, 1'b0); eof_drain();
        rtu(1'b0, 11'h0, 1'b0, 3'd0);
        checks++; if (n_flush !== 1 || n_free !== 1) begin failures++; $display("FAIL drop_pulses got=%0d/%0d exp=1/1", n_flush, n_free); end
        checks++; if (free_pg !== 10'd5) begin failures++; $display("FAIL drop_free_page got=%0d exp=5", free_pg); end
        checks++; if (n_pta !== 0 || n_uc !== 0) begin failures++; $display("FAIL drop_no_pta got=%0d/%0d exp=0/0", n_pta, n_uc); end
        checks++; if (n_ack !== 1 || n_drdy !== 10) begin failures++; $display("FAIL drop_ack_words got=%0d/%0d exp=1/10", n_ack, n_drdy); end
        clr();
        rtu(1'b1, 11'h000, 1'b0, 3'd1);
        sof(); send_words(3, 1'b0); eof_drain();
        rtu(1'b0, 11'h0, 1'b0, 3'd0);
        checks++; if (n_flush !== 1 || n_free !== 1 || free_pg !== 10'd6) begin failures++; $display("FAIL zero_mask_drop got=%0d/%0d/%0d exp=1/1/6", n_flush, n_free, free_pg); end
        checks++; if (n_pta !== 0) begin failures++; $display("FAIL zero_mask_no_pta got=%0d exp=0", n_pta); end
    endtask

    task automatic test_rerror();
        int g = 0;
        do_reset();
        sof(); send_words(5, 1'b0);
        b.tx_rerror_p1_i = 1'b1; tick(); b.tx_rerror_p1_i = 1'b0;
        repeat (4) tick();
        checks++; if (n_flush !== 1 || n_free !== 1 || free_pg !== 10'd5) begin failures++; $display("FAIL rerror_flush got=%0d/%0d/%0d exp=1/1/5", n_flush, n_free, free_pg); end
        checks++; if (n_ack !== 0) begin failures++; $display("FAIL rerror_no_early_ack got=%0d exp=0", n_ack); end
        rtu(1'b1, 11'h003, 1'b0, 3'd1);
        while (n_ack == 0 && g < 20) begin tick(); g++; end
        rtu(1'b0, 11'h0, 1'b0, 3'd0);
        repeat (3) tick();
        checks++; if (n_ack !== 1 || n_pta !== 0) begin failures++; $display("FAIL rerror_rtu_consumed got=%0d/%0d exp=1/0", n_ack, n_pta); end
        clr();
        rtu(1'b1, 11'h001, 1'b0, 3'd4);
        sof(); send_words(4, 1'b0); eof_drain();
        rtu(1'b0, 11'h0, 1'b0, 3'd0);
        checks++; if (n_pck !== 1 || pck_pg !== 10'd6) begin failures++; $display("FAIL next_pckstart got=%0d/%0d exp=1/6", n_pck, pck_pg); end
        checks++; if (n_pta !== 1 || pta_pg !== 10'd6 || pta_msk !== 11'h001 || pta_pri !== 3'd4) begin failures++; $display("FAIL next_pta got=%0d/%0d/%h/%0d exp=1/6/001/4", n_pta, pta_pg, pta_msk, pta_pri); end
        checks++; if (uc_val !== 4'd1 || n_flush !== 0 || n_drdy !== 4) begin failures++; $display("FAIL next_frame got=%0d/%0d/%0d exp=1/0/4", uc_val, n_flush, n_drdy); end
    endtask

    task automatic test_full_pageend();
        do_reset();
        rtu(1'b1, 11'h7FF, 1'b0, 3'd7);
        sof(); send_words(5, 1'b0);
        b.mpm_full_i = 1'b1; b.tx_sof_p1_i = 1'b1; tick(); b.tx_sof_p1_i = 1'b0;
        checks++; if (b.tx_dreq_o !== 1'b0) begin failures++; $display("FAIL full_dreq got=%b exp=0", b.tx_dreq_o); end
        tick(); tick();
        checks++; if (b.tx_dreq_o !== 1'b0) begin failures++; $display("FAIL full_dreq_hold got=%b exp=0", b.tx_dreq_o); end
        b.mpm_full_i = 1'b0; tick();
        checks++; if (b.tx_dreq_o !== 1'b1) begin failures++; $display("FAIL unfull_dreq got=%b exp=1", b.tx_dreq_o); end
        checks++; if (b.mpm_pageaddr_o !== 10'd5) begin failures++; $display("FAIL first_page got=%0d exp=5", b.mpm_pageaddr_o); end
        b.mpm_pageend_i = 1'b1; tick(); b.mpm_pageend_i = 1'b0;
        checks++; if (b.mpm_pageaddr_o !== 10'd6) begin failures++; $display("FAIL pageend_switch got=%0d exp=6", b.mpm_pageaddr_o); end
        checks++; if (b.tx_dreq_o !== 1'b0) begin failures++; $display("FAIL pageend_no_spare got=%b exp=0", b.tx_dreq_o); end
        send_words(5, 1'b0);
        eof_drain();
        rtu(1'b0, 11'h0, 1'b0, 3'd0);
        checks++; if (n_drdy !== 10 || n_pck !== 1) begin failures++; $display("FAIL full_frame got=%0d/%0d exp=10/1", n_drdy, n_pck); end
        checks++; if (n_pta !== 1 || pta_pg !== 10'd5 || pta_msk !== 11'h7FF || pta_pri !== 3'd7) begin failures++; $display("FAIL full_pta got=%0d/%0d/%h/%0d exp=1/5/7ff/7", n_pta, pta_pg, pta_msk, pta_pri); end
        checks++; if (uc_val !== 4'd11) begin failures++; $display("FAIL full_usecnt got=%0d exp=11", uc_val); end
    endtask

    initial begin
        b.tx_data_i = '0; b.tx_ctrl_i = '0; b.tx_bytesel_i = 0; b.tx_valid_i = 0;
        b.tx_sof_p1_i = 0; b.tx_eof_p1_i = 0; b.tx_rerror_p1_i = 0;
        b.mmu_page_alloc_done_i = 0; b.mmu_pageaddr_i = '0; b.mmu_set_usecnt_done_i = 0;
        b.rtu_rsp_valid_i = 0; b.rtu_dst_port_mask_i = '0; b.rtu_drop_i = 0; b.rtu_prio_i = '0;
        b.mpm_pageend_i = 0; b.mpm_full_i = 0;
        clr();
        test_reset();
        test_frame();
        test_drop();
        test_rerror();
        test_full_pageend();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
